// File: rtl/display_timing_generator.sv
// Raster timing generator: pixel-rate strobe, hsync/vsync, display enable and visible x/y.
// Optional frame counter output enabled by defining DISPLAY_TIMING_FRAME_COUNTER_EN.
module display_timing_generator #(
  parameter int clk_div       = 4,
  parameter int screen_width  = 640,
  parameter int h_front       = 16,
  parameter int h_sync        = 96,
  parameter int h_back        = 48,
  parameter int screen_height = 480,
  parameter int v_front       = 10,
  parameter int v_sync        = 2,
  parameter int v_back        = 33,
  parameter bit sync_pol      = 1'b0,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pixel_tick,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic [w_x-1:0] x,
  output logic [w_y-1:0] y,
  output logic           frame_start
`ifdef DISPLAY_TIMING_FRAME_COUNTER_EN
  ,
  output logic [7:0]     frame_num
`endif
);

  localparam int h_total = screen_width + h_front + h_sync + h_back;
  localparam int v_total = screen_height + v_front + v_sync + v_back;
  localparam int hw = $clog2(h_total);
  localparam int vw = $clog2(v_total);
  localparam int dw = (clk_div > 1) ? $clog2(clk_div) : 1;

  localparam logic [dw-1:0] dc_last  = dw'(clk_div - 1);
  localparam logic [hw-1:0] h_last   = hw'(h_total - 1);
  localparam logic [vw-1:0] v_last   = vw'(v_total - 1);
  localparam logic [hw-1:0] h_vis    = hw'(screen_width);
  localparam logic [vw-1:0] v_vis    = vw'(screen_height);
  localparam logic [hw-1:0] hs_first = hw'(screen_width + h_front);
  localparam logic [hw-1:0] hs_final = hw'(screen_width + h_front + h_sync - 1);
  localparam logic [vw-1:0] vs_first = vw'(screen_height + v_front);
  localparam logic [vw-1:0] vs_final = vw'(screen_height + v_front + v_sync - 1);

  if (clk_div < 1) begin : g_bad_div
    $error("display_timing_generator: clk_div must be >= 1");
  end
  if (h_sync < 1) begin : g_bad_hsync
    $error("display_timing_generator: h_sync must be >= 1");
  end
  if (v_sync < 1) begin : g_bad_vsync
    $error("display_timing_generator: v_sync must be >= 1");
  end

  logic          run;
  logic [dw-1:0] dc, dc_n;
  logic [hw-1:0] hc, hc_n;
  logic [vw-1:0] vc, vc_n;
  logic          tick, h_wrap, v_wrap;
  logic          disp_n, hs_n, vs_n, fs_n;

  // run gates the divider for one edge after reset so (0,0) is shown for a full clk_div cycles
  assign tick       = run && (dc == dc_last);
  assign h_wrap     = (hc == h_last);
  assign v_wrap     = (vc == v_last);
  assign pixel_tick = tick;

  always_comb begin
    dc_n = dc;
    hc_n = hc;
    vc_n = vc;
    if (run) begin
      dc_n = (dc == dc_last) ? '0 : dc + 1'b1;
    end
    if (tick) begin
      if (h_wrap) begin
        hc_n = '0;
        vc_n = v_wrap ? '0 : vc + 1'b1;
      end else begin
        hc_n = hc + 1'b1;
      end
    end
    disp_n = (hc_n < h_vis) && (vc_n < v_vis);
    hs_n   = (hc_n >= hs_first) && (hc_n <= hs_final);
    vs_n   = (vc_n >= vs_first) && (vc_n <= vs_final);
    fs_n   = (hc_n == '0) && (vc_n == '0);
  end

  // Outputs load from the same next-state values as the counters, so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run         <= 1'b0;
      dc          <= '0;
      hc          <= '0;
      vc          <= '0;
      display_on  <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~sync_pol;
      vsync       <= ~sync_pol;
      frame_start <= 1'b0;
    end else begin
      run         <= 1'b1;
      dc          <= dc_n;
      hc          <= hc_n;
      vc          <= vc_n;
      display_on  <= disp_n;
      x           <= disp_n ? hc_n[w_x-1:0] : '0;
      y           <= disp_n ? vc_n[w_y-1:0] : '0;
      hsync       <= hs_n ? sync_pol : ~sync_pol;
      vsync       <= vs_n ? sync_pol : ~sync_pol;
      frame_start <= fs_n;
    end
  end

`ifdef DISPLAY_TIMING_FRAME_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_num <= 8'd0;
    end else if (tick && h_wrap && v_wrap) begin
      frame_num <= frame_num + 8'd1;
    end
  end
`endif

endmodule
